pid_ctrl_param: RTL and testbench
=================================

Name: pid_ctrl_param

Overview:
- Parametrised, pipelined PID heading controller.
- Converts a signed heading error into left and right wheel speed commands around a forward speed.
- Sits between the heading-error source and the motor/PWM drive.
- Over the fixed-gain predecessor it adds: runtime-programmable gains, configurable derivative lag depth, a saturating PID sum, zero-clamp of negative speeds, a synchronous integrator/history flush, and an output-valid strobe.

Parameters:
ERR_W, 12, width of the raw signed error input
ERR_SAT_W, 10, signed width that the error is saturated to
KP_W, 6, unsigned width of the kp input
KD_W, 5, unsigned width of the kd input
D_SAT_W, 8, signed width that the derivative difference is saturated to
D_DEPTH, 3, number of valid samples back used for the derivative (>=1)
INT_W, 15, signed integrator width
I_SHIFT, 6, arithmetic right shift from integrator to I term
PID_W, 14, signed width of the PID sum
OUT_SHIFT, 3, arithmetic right shift from PID sum to speed correction
SPD_W, 11, width of frwrd extension and of the speed outputs

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
moving  in  1  robot moving; low clears integrator and zeroes speeds
err_vld  in  1  error qualifies this cycle
error  in  ERR_W  signed heading error
frwrd  in  SPD_W-1  unsigned forward speed
kp  in  KP_W  unsigned proportional gain, sampled at S1
kd  in  KD_W  unsigned derivative gain, sampled at S1
clr_int  in  1  synchronous flush of integrator and derivative history
lft_spd  out  SPD_W  left speed, range 0..2^(SPD_W-1)-1
rght_spd  out  SPD_W  right speed, same range
spd_vld  out  1  one-cycle strobe: speeds updated

Behaviour:
- Reset (async): all pipeline registers, integrator, history, lft_spd, rght_spd and spd_vld go to 0.
- S0 (combinational): err_sat = error saturated to [-2^(ERR_SAT_W-1), 2^(ERR_SAT_W-1)-1].
- S1 register: err_sat and err_vld are captured every cycle.
- P term: P = err_sat_s1 * kp, signed.
- I term:
  - sum = integrator + sign-extended err_sat_s1.
  - The integrator updates only when valid_s1 & moving & no signed overflow.
  - On overflow the integrator holds.
  - moving=0 or clr_int=1 clears it to 0 on the next edge; clear has priority over update.
  - I = integrator >>> I_SHIFT, using the pre-update value.
- D term:
  - hist is a D_DEPTH-entry shift register of err_sat_s1. It shifts only on valid_s1 and is cleared by clr_int.
  - diff = err_sat_s1 - hist[D_DEPTH-1], saturated to D_SAT_W bits.
  - D = diff_sat * kd.
- S2 register:
  - PID = (P>>>1) + I + D, computed at full width, then clamped to [-2^(PID_W-1), 2^(PID_W-1)-1].
  - valid_s2 <= valid_s1.
- S3 register:
  - corr = PID>>>OUT_SHIFT.
  - l = frwrd + corr; r = frwrd - corr.
  - Each is clamped to 0..2^(SPD_W-1)-1, so negative results give 0.
  - moving=0 forces both speeds to 0.
  - spd_vld <= valid_s2.
- Latency: err_vld at cycle N gives spd_vld and the new speeds at N+3. Throughput is one sample per cycle.
- Between strobes, speed outputs hold their last value.
- Reset mid-pipeline: in-flight samples are discarded and no spd_vld is produced for them.

Decomposition:
- pid_pkg holds:
  - parameter defaults;
  - a function sat_signed(value, width) used for the error, D, PID and speed clamps;
  - default gains KP_DEF=6'h10 and KD_DEF=5'h07.
- One natural sub-module, pid_deriv_hist: the D_DEPTH history plus the saturated difference.

Test Plan:
All cases use defaults, kp=16, kd=7, moving=1, with state cleared first unless stated.
1. Basic: error=100, frwrd=512, single err_vld.
   - P=800, I=0, D=700, PID=1500, corr=187.
   - At N+3: lft=699, rght=325, spd_vld high for exactly 1 cycle.
2. Positive saturation: error=0x7FF, frwrd=1023.
   - err_sat=511, D diff clamped to 127, PID=4977, corr=622.
   - lft clamps to 1023, rght=401.
3. Negative saturation: error=0x800, frwrd=256.
   - err_sat=-512, PID=-4992, corr=-624.
   - lft clamps to 0, rght=880.
4. Windup: error=511 valid on 40 consecutive cycles.
   - Integrator climbs by 511 per update and freezes at 16352 from the 33rd update on.
   - I_term stays at 255.
5. Derivative lag: error=100 on 4 consecutive valids.
   - diffs are 100, 100, 100, 0.
   - With err_vld gaps inserted, hist does not shift and the diff is unchanged.
6. Clear and moving:
   - clr_int during run: integrator and hist are 0 on the next edge.
   - moving low: integrator is 0 and both speeds are 0 at the next spd_vld.
   - rst_n pulsed mid-stream: all outputs are 0 asynchronously and no stray spd_vld follows.

Source files
------------

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared parameter defaults and saturation helper for the PID heading controller
package pid_pkg;
    localparam int ERR_W_DEF     = 12;
    localparam int ERR_SAT_W_DEF = 10;
    localparam int KP_W_DEF      = 6;
    localparam int KD_W_DEF      = 5;
    localparam int D_SAT_W_DEF   = 8;
    localparam int D_DEPTH_DEF   = 3;
    localparam int INT_W_DEF     = 15;
    localparam int I_SHIFT_DEF   = 6;
    localparam int PID_W_DEF     = 14;
    localparam int OUT_SHIFT_DEF = 3;
    localparam int SPD_W_DEF     = 11;

    localparam logic [5:0] KP_DEF = 6'h10;
    localparam logic [4:0] KD_DEF = 5'h07;

    // All datapath arithmetic is done at 32 bits, so clamping happens in one place.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction
endpackage

// File: rtl/pid_deriv_hist.sv
// rtl/pid_deriv_hist.sv - error history shift register and saturated derivative difference
module pid_deriv_hist
    import pid_pkg::*;
#(
    parameter int ERR_SAT_W = ERR_SAT_W_DEF,
    parameter int D_SAT_W   = D_SAT_W_DEF,
    parameter int D_DEPTH   = D_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        shift_i,
    input  logic                        clr_i,
    input  logic signed [ERR_SAT_W-1:0] err_i,
    output logic signed [D_SAT_W-1:0]   diff_sat_o
);
    logic signed [ERR_SAT_W-1:0] hist_q [D_DEPTH];
    logic signed [ERR_SAT_W-1:0] hist_d [D_DEPTH];
    logic signed [31:0]          diff;

    // Only qualified samples enter the history, so the lag counts valid samples, not cycles.
    always_comb begin
        for (int i = 0; i < D_DEPTH; i++) hist_d[i] = hist_q[i];
        if (clr_i) begin
            for (int i = 0; i < D_DEPTH; i++) hist_d[i] = '0;
        end else if (shift_i) begin
            hist_d[0] = err_i;
            for (int i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign diff       = 32'(err_i) - 32'(hist_q[D_DEPTH-1]);
    assign diff_sat_o = D_SAT_W'(sat_signed(diff, D_SAT_W));
endmodule

// File: rtl/pid_ctrl_param.sv
// rtl/pid_ctrl_param.sv - three-stage PID heading controller producing left/right wheel speeds
module pid_ctrl_param
    import pid_pkg::*;
#(
    parameter int ERR_W     = ERR_W_DEF,
    parameter int ERR_SAT_W = ERR_SAT_W_DEF,
    parameter int KP_W      = KP_W_DEF,
    parameter int KD_W      = KD_W_DEF,
    parameter int D_SAT_W   = D_SAT_W_DEF,
    parameter int D_DEPTH   = D_DEPTH_DEF,
    parameter int INT_W     = INT_W_DEF,
    parameter int I_SHIFT   = I_SHIFT_DEF,
    parameter int PID_W     = PID_W_DEF,
    parameter int OUT_SHIFT = OUT_SHIFT_DEF,
    parameter int SPD_W     = SPD_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    moving_i,
    input  logic                    err_vld_i,
    input  logic signed [ERR_W-1:0] error_i,
    input  logic [SPD_W-2:0]        frwrd_i,
    input  logic [KP_W-1:0]         kp_i,
    input  logic [KD_W-1:0]         kd_i,
    input  logic                    clr_int_i,
    output logic [SPD_W-1:0]        lft_spd_o,
    output logic [SPD_W-1:0]        rght_spd_o,
    output logic                    spd_vld_o
);
    logic signed [ERR_SAT_W-1:0] err_sat;
    logic signed [ERR_SAT_W-1:0] err_s1_q;
    logic                        vld_s1_q;

    logic signed [INT_W-1:0]     integ_q;
    logic signed [INT_W-1:0]     integ_d;
    logic signed [INT_W:0]       int_sum;
    logic                        int_ovf;

    logic signed [D_SAT_W-1:0]   diff_sat;
    logic signed [31:0]          kp_ext;
    logic signed [31:0]          kd_ext;
    logic signed [31:0]          p_term;
    logic signed [31:0]          i_term;
    logic signed [31:0]          d_term;
    logic signed [31:0]          pid_full;

    logic signed [PID_W-1:0]     pid_d;
    logic signed [PID_W-1:0]     pid_q;
    logic                        vld_s2_q;

    logic signed [31:0]          corr;
    logic signed [31:0]          frwrd_ext;
    logic signed [31:0]          lft_full;
    logic signed [31:0]          rght_full;
    logic signed [31:0]          lft_sat;
    logic signed [31:0]          rght_sat;
    logic [SPD_W-1:0]            lft_d;
    logic [SPD_W-1:0]            rght_d;
    logic [SPD_W-1:0]            lft_q;
    logic [SPD_W-1:0]            rght_q;
    logic                        spd_vld_q;

    assign err_sat = ERR_SAT_W'(sat_signed(32'(error_i), ERR_SAT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_s1_q <= '0;
            vld_s1_q <= 1'b0;
        end else begin
            err_s1_q <= err_sat;
            vld_s1_q <= err_vld_i;
        end
    end

    // One guard bit detects signed overflow; on overflow the integrator simply holds.
    assign int_sum = {integ_q[INT_W-1], integ_q} + (INT_W+1)'(err_s1_q);
    assign int_ovf = int_sum[INT_W] != int_sum[INT_W-1];

    always_comb begin
        integ_d = integ_q;
        if (clr_int_i || !moving_i) begin
            integ_d = '0;
        end else if (vld_s1_q && !int_ovf) begin
            integ_d = int_sum[INT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) integ_q <= '0;
        else        integ_q <= integ_d;
    end

    pid_deriv_hist #(
        .ERR_SAT_W (ERR_SAT_W),
        .D_SAT_W   (D_SAT_W),
        .D_DEPTH   (D_DEPTH)
    ) u_deriv (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_i    (vld_s1_q),
        .clr_i      (clr_int_i),
        .err_i      (err_s1_q),
        .diff_sat_o (diff_sat)
    );

    assign kp_ext   = 32'(kp_i);
    assign kd_ext   = 32'(kd_i);
    assign p_term   = 32'(err_s1_q) * kp_ext;
    assign i_term   = 32'(integ_q) >>> I_SHIFT;
    assign d_term   = 32'(diff_sat) * kd_ext;
    assign pid_full = (p_term >>> 1) + i_term + d_term;
    assign pid_d    = PID_W'(sat_signed(pid_full, PID_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_q    <= '0;
            vld_s2_q <= 1'b0;
        end else begin
            pid_q    <= pid_d;
            vld_s2_q <= vld_s1_q;
        end
    end

    assign corr      = 32'(pid_q) >>> OUT_SHIFT;
    assign frwrd_ext = 32'(frwrd_i);
    assign lft_full  = frwrd_ext + corr;
    assign rght_full = frwrd_ext - corr;
    assign lft_sat   = sat_signed(lft_full, SPD_W);
    assign rght_sat  = sat_signed(rght_full, SPD_W);

    // A wheel never reverses: negative commands floor at zero.
    assign lft_d  = (lft_sat < 0)  ? '0 : SPD_W'(lft_sat);
    assign rght_d = (rght_sat < 0) ? '0 : SPD_W'(rght_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q     <= '0;
            rght_q    <= '0;
            spd_vld_q <= 1'b0;
        end else begin
            spd_vld_q <= vld_s2_q;
            if (!moving_i) begin
                lft_q  <= '0;
                rght_q <= '0;
            end else if (vld_s2_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
        end
    end

    assign lft_spd_o  = lft_q;
    assign rght_spd_o = rght_q;
    assign spd_vld_o  = spd_vld_q;
endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb/tb_pid_ctrl_param.sv - scoreboard bench for pid_ctrl_param with hand-computed vectors
module tb_pid_ctrl_param;
    import pid_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               moving;
    logic               err_vld;
    logic signed [11:0] error;
    logic [9:0]         frwrd;
    logic [5:0]         kp;
    logic [4:0]         kd;
    logic               clr_int;
    logic [10:0]        lft;
    logic [10:0]        rght;
    logic               spd_vld;

    typedef struct {
        int    lft;
        int    rght;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    pid_ctrl_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .moving_i   (moving),
        .err_vld_i  (err_vld),
        .error_i    (error),
        .frwrd_i    (frwrd),
        .kp_i       (kp),
        .kd_i       (kd),
        .clr_int_i  (clr_int),
        .lft_spd_o  (lft),
        .rght_spd_o (rght),
        .spd_vld_o  (spd_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && spd_vld) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_spd_vld", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_lft"},  int'(lft),  e.lft);
                chk({e.name, "_rght"}, int'(rght), e.rght);
                chk({e.name, "_cyc"},  cyc,        e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int e, input int fw, input int el, input int er,
                        input string nm, input bit push);
        error   = 12'(e);
        frwrd   = 10'(fw);
        err_vld = 1'b1;
        if (push) sb_q.push_back('{el, er, cyc + 3, nm});
        tick(1);
        err_vld = 1'b0;
    endtask

    task automatic gap(input int n);
        error   = 12'(-300);
        err_vld = 1'b0;
        tick(n);
    endtask

    task automatic clear_state();
        clr_int = 1'b1;
        tick(1);
        clr_int = 1'b0;
        tick(1);
    endtask

    initial begin
        int c;
        int i_t;
        rst_n   = 1'b1;
        moving  = 1'b1;
        err_vld = 1'b0;
        error   = '0;
        frwrd   = '0;
        kp      = KP_DEF;
        kd      = KD_DEF;
        clr_int = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_lft",  int'(lft),     0);
        chk("rst_rght", int'(rght),    0);
        chk("rst_vld",  int'(spd_vld), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // basic and saturation vectors
        clear_state();
        send(100, 512, 699, 325, "basic", 1'b1);
        tick(4);
        clear_state();
        send(2047, 1023, 1023, 401, "pos_sat", 1'b1);
        tick(4);
        clear_state();
        send(-2048, 256, 0, 880, "neg_sat", 1'b1);
        tick(4);

        // derivative lag, back to back and with gaps
        clear_state();
        send(100, 512, 699, 325, "lag0", 1'b1);
        send(100, 512, 699, 325, "lag1", 1'b1);
        send(100, 512, 699, 325, "lag2", 1'b1);
        send(100, 512, 612, 412, "lag3", 1'b1);
        tick(4);
        clear_state();
        send(100, 512, 699, 325, "gap0", 1'b1);
        gap(1);
        send(100, 512, 699, 325, "gap1", 1'b1);
        gap(2);
        send(100, 512, 699, 325, "gap2", 1'b1);
        send(100, 512, 612, 412, "gap3", 1'b1);
        tick(4);

        // windup with only the I term active
        clear_state();
        kp = '0;
        kd = '0;
        for (int k = 0; k < 40; k++) begin
            i_t = (511 * ((k < 32) ? k : 32)) / 64;
            c   = i_t / 8;
            send(511, 512, 512 + c, 512 - c, $sformatf("wind%0d", k), 1'b1);
        end
        tick(4);
        chk("wind_integ", int'(dut.integ_q), 16352);
        kp = KP_DEF;
        kd = KD_DEF;

        // clear wins over a pending integrator update
        clear_state();
        send(100, 512, 699, 325, "clr0", 1'b1);
        send(100, 512, 699, 325, "clr1", 1'b1);
        clr_int = 1'b1;
        tick(1);
        clr_int = 1'b0;
        chk("clr_integ", int'(dut.integ_q), 0);
        for (int i = 0; i < D_DEPTH_DEF; i++)
            chk($sformatf("clr_hist%0d", i), int'(dut.u_deriv.hist_q[i]), 0);
        tick(3);
        send(100, 512, 699, 325, "clr_after", 1'b1);
        tick(4);

        // moving low
        clear_state();
        send(100, 512, 699, 325, "mov0", 1'b1);
        send(100, 512, 699, 325, "mov1", 1'b1);
        tick(4);
        moving = 1'b0;
        tick(2);
        chk("mov_hold_lft",  int'(lft),  0);
        chk("mov_hold_rght", int'(rght), 0);
        chk("mov_integ0",    int'(dut.integ_q), 0);
        send(100, 512, 0, 0, "mov_low", 1'b1);
        tick(4);
        chk("mov_integ1", int'(dut.integ_q), 0);
        moving = 1'b1;

        // reset with samples in flight
        clear_state();
        send(100, 512, 699, 325, "pre_rst", 1'b1);
        tick(4);
        send(-50, 300, 0, 0, "lost0", 1'b0);
        send(-50, 300, 0, 0, "lost1", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_lft",  int'(lft),     0);
        chk("mid_rst_rght", int'(rght),    0);
        chk("mid_rst_vld",  int'(spd_vld), 0);
        tick(1);
        #3 rst_n = 1'b1;
        tick(8);
        chk("post_rst_lft", int'(lft), 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
